// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bundle for the iterative divider.
interface seq_divider_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, one quotient bit per clock; results held until the next DONE.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; results from the last operation held
// RUN   | shifting/subtracting, one quotient bit per cycle, N cycles
// DONE  | one-cycle result strobe; a start here is accepted immediately
module seq_divider #(
    parameter int N = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    logic [N:0]   r;
    logic [N-1:0] q;
    logic [N-1:0] d;
    logic [CW-1:0] cnt;
    logic [N-1:0] quotient_r;
    logic [N-1:0] remainder_r;
    logic         dbz_r;

    logic [N:0]   t;
    logic [N:0]   r_next;
    logic [N-1:0] q_next;
    logic         ge;
    logic         accept;

    assign t      = {r[N-1:0], q[N-1]};
    assign ge     = (t >= {1'b0, d});
    assign r_next = ge ? (t - {1'b0, d}) : t;
    assign q_next = {q[N-2:0], ge};
    assign accept = bus.start && (state != RUN);

    // A restoring step always leaves R < D, so the top remainder bit is never observed.
    logic unused_r_msb;
    assign unused_r_msb = r[N] ^ r_next[N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            r           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            dbz_r       <= 1'b0;
        end else if (accept) begin
            d     <= bus.divisor;
            r     <= '0;
            q     <= bus.dividend;
            cnt   <= CW'(N);
            dbz_r <= 1'b0;
            if (bus.divisor == '0) begin
                state       <= DONE;
                quotient_r  <= '1;
                remainder_r <= bus.dividend;
                dbz_r       <= 1'b1;
            end else begin
                state <= RUN;
            end
        end else begin
            case (state)
                RUN: begin
                    r   <= r_next;
                    q   <= q_next;
                    cnt <= cnt - CW'(1);
                    // Last step: publish the values this step produces.
                    if (cnt == CW'(1)) begin
                        state       <= DONE;
                        quotient_r  <= q_next;
                        remainder_r <= r_next[N-1:0];
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = (state == RUN);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider against a floor/mod reference model.
module tb_seq_divider;
    localparam int N = 8;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_mis;
    logic [N-1:0] prev_q;
    logic [N-1:0] prev_r;

    seq_divider_if #(.N(N)) bus ();

    seq_divider #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issues one divide from the current sample point and follows it to its done cycle.
    // Leaves the bench sampling inside the done cycle so a caller may chain back-to-back.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input int intrude_at);
        int unsigned exp_q;
        int unsigned exp_r;
        int unsigned exp_z;
        int          lat;
        int          busy_cnt;
        if (b == 0) begin
            exp_q = (1 << N) - 1;
            exp_r = a;
            exp_z = 1;
        end else begin
            exp_q = a / b;
            exp_r = a % b;
            exp_z = 0;
        end
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        tick();
        bus.start = 1'b0;
        lat       = 1;
        busy_cnt  = 0;
        if (b != 0) begin
            check("held_quotient", 32'(bus.quotient), 32'(prev_q));
            check("held_remainder", 32'(bus.remainder), 32'(prev_r));
            check("dbz_cleared", 32'(bus.div_by_zero), 0);
        end
        while (!bus.done && lat < 20) begin
            if (bus.busy) busy_cnt++;
            if (lat == intrude_at) begin
                bus.start    = 1'b1;
                bus.dividend = 8'd50;
                bus.divisor  = 8'd5;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            lat++;
        end
        bus.start = 1'b0;
        check("done_seen", 32'(bus.done), 1);
        check("latency", 32'(lat), (b == 0) ? 1 : N + 1);
        check("busy_cycles", 32'(busy_cnt), (b == 0) ? 0 : N);
        check("busy_in_done", 32'(bus.busy), 0);
        check("quotient", 32'(bus.quotient), exp_q);
        check("remainder", 32'(bus.remainder), exp_r);
        check("div_by_zero", 32'(bus.div_by_zero), exp_z);
        prev_q = bus.quotient;
        prev_r = bus.remainder;
    endtask

    task automatic idle_after_done();
        tick();
        check("done_single_pulse", 32'(bus.done), 0);
        check("idle_not_busy", 32'(bus.busy), 0);
    endtask

    initial begin
        n_cmp        = 0;
        n_mis        = 0;
        prev_q       = '0;
        prev_r       = '0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        tick();
        tick();
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_quotient", 32'(bus.quotient), 0);
        check("rst_remainder", 32'(bus.remainder), 0);
        check("rst_dbz", 32'(bus.div_by_zero), 0);
        rst_n = 1'b1;
        tick();
        check("idle_done", 32'(bus.done), 0);

        // Basic and extreme operands
        run_op(8'd100, 8'd7, -1);
        idle_after_done();
        run_op(8'd255, 8'd1, -1);
        idle_after_done();
        run_op(8'd5, 8'd10, -1);
        idle_after_done();
        run_op(8'd255, 8'd255, -1);
        idle_after_done();

        // Divide by zero, then a normal divide clears the flag
        run_op(8'd37, 8'd0, -1);
        idle_after_done();
        run_op(8'd9, 8'd3, -1);
        idle_after_done();

        // Start while busy is ignored; start in the done cycle is accepted
        run_op(8'd200, 8'd9, 3);
        run_op(8'd50, 8'd5, -1);
        idle_after_done();

        // Reset in the middle of an operation
        bus.start    = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 8'd7;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        check("busy_before_reset", 32'(bus.busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(bus.busy), 0);
        check("async_rst_done", 32'(bus.done), 0);
        check("async_rst_quotient", 32'(bus.quotient), 0);
        check("async_rst_remainder", 32'(bus.remainder), 0);
        check("async_rst_dbz", 32'(bus.div_by_zero), 0);
        tick();
        rst_n = 1'b1;
        prev_q = '0;
        prev_r = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("no_done_after_reset", 32'(bus.done), 0);
            check("no_busy_after_reset", 32'(bus.busy), 0);
        end

        // Randomized sweep, sometimes chained back-to-back
        for (int k = 0; k < 2000; k++) begin
            logic [N-1:0] a;
            logic [N-1:0] b;
            a = N'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            run_op(a, b, -1);
            if ($urandom_range(0, 1) == 0) idle_after_done();
        end
        idle_after_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative unsigned radix-2 restoring divider producing N-bit quotient and remainder, one quotient bit per clock. It is the inverse of the combinational Booth `Multiplier` used in the FFT datapath. It serves normalisation and scaling paths where a single-cycle divide is not needed. Operands are accepted with a start/busy/done handshake, and results are held stable until the next accepted operation.

## Interface
- `N`, default 8: operand and result width in bits (N ≥ 2).
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request a divide. Accepted only while `busy`=0.
- `dividend`, input, N: unsigned dividend. Sampled on the accepting edge.
- `divisor`, input, N: unsigned divisor. Sampled on the accepting edge.
- `busy`, output, 1: high while iterating. New `start` is ignored while it is high.
- `done`, output, 1: one-cycle pulse; results are valid from this cycle onward.
- `quotient`, output, N: floor(dividend/divisor).
- `remainder`, output, N: dividend mod divisor.
- `div_by_zero`, output, 1: set with `done` when the captured divisor is 0. Held with the results.

## Operation
- **States:**
  - IDLE: reset state.
  - RUN: iterating.
  - DONE: one cycle.
- **Accept:** `start`=1 at a rising edge while in IDLE or DONE.
  - Captures the operands.
  - Clears `div_by_zero`.
  - Loads the partial remainder R (N+1 bits) with 0, the shift register Q with `dividend`, and the step counter with N.
- **Transitions:**
  - Accept with nonzero divisor → RUN.
  - Accept with zero divisor → DONE directly.
  - RUN stays for exactly N cycles (counter decrements each cycle), then → DONE.
  - DONE → IDLE, unless a new accept occurs in the same cycle, in which case → RUN or DONE per the accept rule.
- **RUN step (one per cycle):**
  - T = {R[N-1:0], Q[N-1]}.
  - If T ≥ {1'b0, D}: R ← T − D and Q ← {Q[N-2:0], 1}.
  - Else: R ← T and Q ← {Q[N-2:0], 0}.
  - All compare and subtract is done at N+1 bits. No signed arithmetic.
- **On entering DONE (normal divide):** `quotient` ← Q, `remainder` ← R[N-1:0].
- **On entering DONE (divide by zero):** `quotient` ← all ones, `remainder` ← `dividend`, `div_by_zero` ← 1.
- **Result holding:** `quotient`, `remainder` and `div_by_zero` are registers. They change only on entry to DONE, except that `div_by_zero` also clears on accept.
  - Between accept and the next DONE, `quotient` and `remainder` keep their previous values.
- **Flag decode:** `busy` = (state == RUN). `done` = (state == DONE). Both are registered-state decodes, glitch-free.
- **Ignored start:** `start` while `busy`=1 has no effect. Operands, counter and state are unchanged.

## Timing
- **Reset:** asserting `rst_n` low forces, asynchronously:
  - state=IDLE;
  - `busy`=0, `done`=0;
  - `quotient`=0, `remainder`=0, `div_by_zero`=0;
  - internal R, Q and counter = 0.
- **Reset mid-RUN:** the operation is aborted. No `done` is issued after release, and the IDLE requirements apply on the first edge after deassertion.
- **Cycle numbering:** the accepting edge is edge 0.
- **Normal divide:**
  - `busy` is high after edges 0..N-1, i.e. for N cycles.
  - `done` is high for the single cycle after edge N.
  - Latency from accepting edge to `done` is N+1 edges, counting the edge that registers `done`.
- **Divide by zero:** `done` is high the cycle after edge 0. `busy` never rises.
- **Back-to-back:** `start` high during the `done` cycle is accepted at the following edge. Sustained throughput is one result per N+1 cycles.
- **`start` duration:** `start` is level-sampled. Holding it high causes repeated operations, one per DONE cycle.

## Test plan
- **Basic divide:** N=8, reset, then `start` with dividend=100, divisor=7.
  - `busy` high for 8 cycles.
  - `done` pulse 9 edges after accept.
  - quotient=14, remainder=2, div_by_zero=0.
- **Extremes:** 255/1 → q=255, r=0. Then 5/10 → q=0, r=5. Then 255/255 → q=1, r=0.
- **Divide by zero:** 37/0.
  - `done` on the cycle after accept, `busy` never high.
  - q=255, r=37, div_by_zero=1.
  - A following 9/3 returns q=3, r=0 with div_by_zero=0.
- **Start while busy:** start 200/9, then pulse start with 50/5 at cycle 3.
  - It is ignored; the result is q=22, r=2.
  - Exactly one `done` pulse.
  - Then start during the `done` cycle with 50/5 → q=10, r=0 after a further 9 edges.
- **Reset mid-operation:** start 100/7 and assert `rst_n`=0 at cycle 4.
  - All outputs go to 0 immediately.
  - After release, no `done` appears within 20 cycles without a new `start`.
- **Random sweep:** N=8, 2000 random operand pairs including divisor 0.
  - Every result matches the floor/mod reference model.
  - Every nonzero-divisor result has latency exactly 9.
